// File: rtl/area_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// area_scan_ctrl_if
//   Brightness stream carrying one byte per zone into the scan sequencer.
//
//   zone_data   8  brightness of the currently addressed zone
//   zone_valid  1  zone_data is valid
//   zone_ready  1  the sequencer accepts zone_data this cycle
//
//   master : stream source (drives data/valid, observes ready)
//   slave  : area_scan_ctrl (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface area_scan_ctrl_if;
   logic [7:0] zone_data;
   logic       zone_valid;
   logic       zone_ready;

   modport master (output zone_data, zone_valid, input zone_ready);
   modport slave  (input zone_data, zone_valid, output zone_ready);
endinterface

// File: rtl/area_scan_ctrl.sv
// ---------------------------------------------------------------------------
// area_scan_ctrl
//   Per-node scan sequencer for the local-dimming zone grid. Each frame it
//   walks (row_now, col_now) over rows 1..ROWS and columns 0..COLS-1, takes
//   one brightness byte per zone, weights it by the area-judge class of that
//   zone and, after the last zone, commits a saturated 10-bit PWM duty.
//
//   clk          system clock
//   rst          synchronous active-high reset
//   frame_start  single-cycle pulse that (re)starts a scan
//   zone         brightness stream (slave side)
//   row_now      current zone row, to the area-judge block
//   col_now      current zone column, to the area-judge block
//   judge1..3    primary/secondary/tertiary hit for the current address
//   duty         committed LED duty, held between commits
//   duty_valid   one-cycle strobe when duty updates
//   busy         a scan is in progress
// ---------------------------------------------------------------------------
module area_scan_ctrl #(
   parameter int ID   = 2,
   parameter int ROWS = 3,
   parameter int COLS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_start,
   area_scan_ctrl_if.slave        zone,
   output logic [6:0]             row_now,
   output logic [6:0]             col_now,
   input  logic                   judge1,
   input  logic                   judge2,
   input  logic                   judge3,
   output logic [9:0]             duty,
   output logic                   duty_valid,
   output logic                   busy
);

   // The paired area-judge instance must address a column inside the grid,
   // and the grid must fit the 7-bit address bus.
   if (ID < 0 || ID >= COLS || ROWS < 1 || ROWS > 127 || COLS < 1 || COLS > 128) begin : g_param_check
      $error("area_scan_ctrl: ID/ROWS/COLS out of range");
   end

   localparam logic [6:0] ROW_FIRST = 7'd1;
   localparam logic [6:0] ROW_LAST  = 7'(ROWS);
   localparam logic [6:0] COL_LAST  = 7'(COLS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [11:0] acc, acc_nxt;
   logic [6:0]  row_nxt, col_nxt;
   logic [9:0]  duty_nxt;
   logic [7:0]  contrib;
   logic        beat;

   // Fixed judge priority 1 > 2 > 3; the weight is a plain right shift.
   always_comb begin
      contrib = '0;
      if (judge1)      contrib = zone.zone_data;
      else if (judge2) contrib = {1'b0, zone.zone_data[7:1]};
      else if (judge3) contrib = {2'b00, zone.zone_data[7:2]};
   end

   assign zone.zone_ready = (state == S_SCAN);
   assign busy            = (state == S_SCAN);
   assign duty_valid      = (state == S_DONE);
   assign beat            = zone.zone_valid && zone.zone_ready;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      row_nxt   = row_now;
      col_nxt   = col_now;
      duty_nxt  = duty;

      unique case (state)
         S_IDLE: begin
            if (frame_start) begin
               state_nxt = S_SCAN;
               acc_nxt   = '0;
               row_nxt   = ROW_FIRST;
               col_nxt   = '0;
            end
         end

         S_SCAN: begin
            // A restart outranks a coincident beat, which is dropped.
            if (frame_start) begin
               acc_nxt = '0;
               row_nxt = ROW_FIRST;
               col_nxt = '0;
            end else if (beat) begin
               acc_nxt = acc + 12'(contrib);
               if (col_now == COL_LAST) begin
                  col_nxt = '0;
                  if (row_now == ROW_LAST) begin
                     // Last zone: commit now so duty is already valid in DONE,
                     // and park the address at the start position.
                     state_nxt = S_DONE;
                     row_nxt   = ROW_FIRST;
                     duty_nxt  = (acc_nxt > 12'd1023) ? 10'd1023 : acc_nxt[9:0];
                  end else begin
                     row_nxt = row_now + 7'd1;
                  end
               end else begin
                  col_nxt = col_now + 7'd1;
               end
            end
         end

         S_DONE: begin
            if (frame_start) begin
               state_nxt = S_SCAN;
               acc_nxt   = '0;
               row_nxt   = ROW_FIRST;
               col_nxt   = '0;
            end else begin
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values of the same clock edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         acc     <= '0;
         row_now <= ROW_FIRST;
         col_now <= '0;
         duty    <= '0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         row_now <= row_nxt;
         col_now <= col_nxt;
         duty    <= duty_nxt;
      end
   end

endmodule

// File: tb/tb_area_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_area_scan_ctrl
//   Bench for area_scan_ctrl (ID=2, ROWS=3, COLS=8). A stand-in area-judge
//   classifies each zone around the node column; stimulus pushes the expected
//   duty of every frame that should commit into a queue, and a monitor pops
//   and compares on each duty_valid strobe and checks the address on beats.
// ---------------------------------------------------------------------------
module tb_area_scan_ctrl;
   localparam int ID   = 2;
   localparam int ROWS = 3;
   localparam int COLS = 8;
   localparam int NZ   = ROWS * COLS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [6:0] row_now, col_now;
   logic       judge1, judge2, judge3;
   logic [9:0] duty;
   logic       duty_valid, busy;

   area_scan_ctrl_if zif ();

   area_scan_ctrl #(.ID(ID), .ROWS(ROWS), .COLS(COLS)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .zone        (zif.slave),
      .row_now     (row_now),
      .col_now     (col_now),
      .judge1      (judge1),
      .judge2      (judge2),
      .judge3      (judge3),
      .duty        (duty),
      .duty_valid  (duty_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int         exp_q[$];
   logic [7:0] cur_frame [NZ];
   int         beat_idx = 0;
   bit         scanning = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Zone classes around node column ID: 1 primary, 4 secondary, 7 tertiary.
   function automatic int zone_class(input int r, input int c);
      if (r == 1 && c == ID) return 1;
      if ((r == 1 || r == 2) && (c == ID - 1 || c == ID + 1)) return 2;
      if ((r == 2 && c == ID) || (r == 3 && c >= ID - 1 && c <= ID + 1) ||
          (r == 1 && (c == ID - 2 || c == ID + 2)) || (r == 2 && c == ID + 2))
         return 3;
      return 0;
   endfunction

   // Overlapping judges (a primary hit also raises 2 and 3) exercise priority.
   always_comb begin
      int cls;
      cls    = zone_class(int'(row_now), int'(col_now));
      judge1 = (cls == 1);
      judge2 = (cls == 1 || cls == 2);
      judge3 = (cls != 0);
   end

   // Reference: zone i is (1 + i/COLS, i%COLS); weight halves per class step.
   function automatic int model_duty();
      int s = 0;
      for (int i = 0; i < NZ; i++) begin
         int cls;
         cls = zone_class(1 + i / COLS, i % COLS);
         if (cls > 0) s += int'(cur_frame[i]) >> (cls - 1);
      end
      return (s > 1023) ? 1023 : s;
   endfunction

   // Monitor: address on every accepted beat, duty on every commit strobe.
   always @(negedge clk) begin
      int e;
      if (!rst) begin
         if (scanning && zif.zone_valid && zif.zone_ready) begin
            check("beat_row", int'(row_now), 1 + beat_idx / COLS);
            check("beat_col", int'(col_now), beat_idx % COLS);
         end
         if (duty_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_duty_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("duty", int'(duty), e);
               check("busy_in_done", int'(busy), 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < NZ; i++) cur_frame[i] = v;
   endtask

   task automatic start_frame(input bit with_valid);
      frame_start    = 1'b1;
      zif.zone_valid = with_valid;
      zif.zone_data  = 8'hFF;
      tick();
      frame_start    = 1'b0;
      zif.zone_valid = 1'b0;
   endtask

   // Present beats beat_idx..stop-1 of cur_frame with ~vpct% valid density.
   task automatic feed(input int stop, input int vpct, output int cyc);
      bit took;
      cyc      = 0;
      beat_idx = 0;
      scanning = 1'b1;
      while (beat_idx < stop && cyc < 2000) begin
         zif.zone_valid = ($urandom_range(99) < vpct);
         zif.zone_data  = zif.zone_valid ? cur_frame[beat_idx] : 8'($urandom_range(255));
         @(negedge clk);
         took = zif.zone_valid && zif.zone_ready;
         tick();
         cyc++;
         if (took) beat_idx++;
      end
      zif.zone_valid = 1'b0;
      scanning       = 1'b0;
      if (beat_idx < stop) check("feed_timeout", beat_idx, stop);
   endtask

   // Full frame: start, all beats, then the cycle after DONE.
   task automatic run_full(input int exp, input int vpct);
      int cyc;
      exp_q.push_back(exp);
      start_frame(1'b0);
      check("busy_after_start", int'(busy), 1);
      check("ready_after_start", int'(zif.zone_ready), 1);
      feed(NZ, vpct, cyc);
      if (vpct >= 100) check("scan_cycles", cyc, NZ);
      tick();
      check("duty_valid_drop", int'(duty_valid), 0);
      check("busy_idle", int'(busy), 0);
      check("duty_hold", int'(duty), exp);
   endtask

   initial begin
      int cyc;
      zif.zone_valid = 1'b0;
      zif.zone_data  = '0;

      // Reset state
      tick();
      tick();
      check("rst_row", int'(row_now), 1);
      check("rst_col", int'(col_now), 0);
      check("rst_ready", int'(zif.zone_ready), 0);
      check("rst_duty", int'(duty), 0);
      check("rst_duty_valid", int'(duty_valid), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // zone_valid while idle is ignored
      zif.zone_valid = 1'b1;
      zif.zone_data  = 8'hAA;
      repeat (3) tick();
      check("idle_ready", int'(zif.zone_ready), 0);
      check("idle_row", int'(row_now), 1);
      check("idle_col", int'(col_now), 0);
      zif.zone_valid = 1'b0;
      tick();

      // Uniform mid-level and saturation
      fill(8'h80); run_full(608, 100);
      fill(8'hFF); run_full(1023, 100);

      // Single-zone weights: primary, secondary, tertiary
      fill(8'h00); cur_frame[2]  = 8'd200; run_full(200, 100);
      fill(8'h00); cur_frame[1]  = 8'd200; run_full(100, 100);
      fill(8'h00); cur_frame[18] = 8'd200; run_full(50, 100);

      // Backpressure
      fill(8'h80); run_full(608, 50);

      // Abort after beat 10 with a coincident beat, then frame B of 0x40
      fill(8'h80);
      start_frame(1'b0);
      feed(10, 100, cyc);
      frame_start    = 1'b1;
      zif.zone_valid = 1'b1;
      zif.zone_data  = cur_frame[10];
      tick();
      frame_start    = 1'b0;
      zif.zone_valid = 1'b0;
      check("abort_row", int'(row_now), 1);
      check("abort_col", int'(col_now), 0);
      check("abort_busy", int'(busy), 1);
      check("abort_duty_kept", int'(duty), 608);
      fill(8'h40);
      exp_q.push_back(304);
      feed(NZ, 100, cyc);
      tick();
      check("abort_b_duty", int'(duty), 304);

      // Reset mid-scan at beat 5
      fill(8'h80);
      start_frame(1'b0);
      feed(5, 100, cyc);
      rst = 1'b1;
      tick();
      check("mrst_ready", int'(zif.zone_ready), 0);
      check("mrst_busy", int'(busy), 0);
      check("mrst_row", int'(row_now), 1);
      check("mrst_col", int'(col_now), 0);
      check("mrst_duty", int'(duty), 0);
      rst = 1'b0;
      tick();
      run_full(608, 100);

      // Back-to-back: frame_start during DONE goes straight to SCAN
      fill(8'h10);
      exp_q.push_back(76);
      start_frame(1'b0);
      feed(NZ, 100, cyc);
      for (int i = 0; i < NZ; i++) cur_frame[i] = 8'($urandom_range(255));
      exp_q.push_back(model_duty());
      start_frame(1'b0);
      check("b2b_busy", int'(busy), 1);
      feed(NZ, 70, cyc);
      tick();

      // Randomized frames against the reference model
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < NZ; i++) cur_frame[i] = 8'($urandom_range(255));
         run_full(model_duty(), 30 + int'($urandom_range(70)));
         repeat ($urandom_range(3)) tick();
      end

      repeat (4) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/area_scan_ctrl.md
# area_scan_ctrl

Per-node scan sequencer for the backlight local-dimming zone grid. Once per frame it walks the zone address (`row_now`, `col_now`) across the whole grid, which drives the node's area-judge logic. It accepts one brightness byte per zone over a valid/ready stream and weights each byte by the judge class of that zone. At frame end it commits a saturated 10-bit PWM duty for this node's LED driver.

## Interface

Parameters
- `ID`, default 2: node column; must match the `ID` of the area-judge instance fed by this block.
- `ROWS`, default 3: zone rows, addressed 1..`ROWS`.
- `COLS`, default 8: zone columns, addressed 0..`COLS`-1.

Ports
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  single-cycle pulse that begins a scan.
- `zone_data`  in  8  brightness of the currently addressed zone.
- `zone_valid`  in  1  `zone_data` is valid.
- `zone_ready`  out  1  block accepts `zone_data` this cycle.
- `row_now`  out  7  current zone row, wired to the area-judge block.
- `col_now`  out  7  current zone column, wired to the area-judge block.
- `judge1`, `judge2`, `judge3`  in  1 each  primary, secondary and tertiary hit for (`row_now`, `col_now`), combinational from the area-judge block.
- `duty`  out  10  committed LED duty.
- `duty_valid`  out  1  one-cycle strobe when `duty` updates.
- `busy`  out  1  a scan is in progress.

## Operation

States:
- **IDLE**
  - `zone_ready`=0, `busy`=0.
  - Address held at row 1, col 0.
  - `frame_start` → SCAN; the accumulator (`acc`, 12 bits) clears on the same edge.
- **SCAN**
  - `zone_ready`=1, `busy`=1.
  - Beat = `zone_valid`&`zone_ready`. On each beat, add to `acc`:
    - `judge1`: `zone_data`
    - else `judge2`: `zone_data`>>1
    - else `judge3`: `zone_data`>>2
    - else: 0
  - Judge priority is fixed 1>2>3.
  - After each beat, col increments. At col `COLS`-1, col wraps to 0 and row increments.
  - Beat at (`ROWS`, `COLS`-1) → DONE, with the final contribution included.
  - No beat: address and `acc` hold.
- **DONE** (one cycle)
  - `duty` = min(`acc`, 1023); `duty_valid`=1.
  - Next state is IDLE, or SCAN if `frame_start`=1 (accumulator cleared, address reset).

Arithmetic:
- Contributions are zero-extended 8-bit values.
- `acc` max is 255 + 4·127 + 7·63 = 1204, so 12 bits cannot overflow.
- Saturation is applied only at commit.

Boundary conditions:
- `frame_start` in SCAN aborts the scan and restarts at row 1, col 0 with `acc`=0. There is no `duty_valid` for the aborted frame, and `duty` keeps its previous value.
- `frame_start` coincident with a beat: restart wins and the beat is discarded.
- `zone_valid` while IDLE: ignored (`zone_ready`=0).
- `rst` at any time: at the next edge all state returns to reset values. An in-flight scan is lost.

## Timing

- Reset values: `row_now`=1, `col_now`=0, `zone_ready`=0, `duty`=0, `duty_valid`=0, `busy`=0, `acc`=0, state IDLE.
- `row_now`/`col_now` are registered. The judges settle combinationally in the same cycle, so `zone_data` for address (r,c) is accepted in the cycle that address is presented.
- `frame_start` at edge N → `busy`=`zone_ready`=1 from cycle N+1.
- Scan length is `ROWS`·`COLS` beats; with `zone_valid` held high it takes exactly `ROWS`·`COLS` cycles.
- Final beat in cycle M:
  - cycle M+1: DONE, `duty`/`duty_valid` valid, `busy`=0.
  - cycle M+2: IDLE, `duty_valid`=0.
- `duty` holds between commits.

## Test plan

All scenarios use ID=2, ROWS=3, COLS=8.

- **Uniform mid-level:** all 24 zones 0x80, `zone_valid` held high → `duty_valid` one cycle after beat 24, `duty`=608.
- **Saturation:** all zones 0xFF → `duty`=1023 (raw 1204).
- **Primary only:** zone (1,2)=200, all others 0 → `duty`=200. Also check that setting (1,1)=200 instead yields 100, and (3,2)=200 yields 50.
- **Backpressure:** all zones 0x80, `zone_valid` pseudo-random ~50% → `duty`=608. Address advances only on beats; exactly 24 beats accepted.
- **Abort:** frame A aborted by `frame_start` after beat 10, then frame B of all 0x40 → no `duty_valid` for A, address returns to (1,0), `duty`=304.
- **Reset mid-scan:** `rst` at beat 5 → next cycle `zone_ready`=0, `busy`=0, `row_now`=1, `col_now`=0, `duty`=0. A subsequent full 0x80 frame gives 608.
